// File: rtl/skolem_sweep_ctrl_if.sv
// Bundle between the sweep controller and its environment (stimulus, checker, status).
// Latency: none, wires only.
// Backpressure: none; the controller paces itself and the checker must answer combinationally.
// Ports: start/abort and sk_out/spec_ok flow into the controller. vec and all status/result
// signals flow out of it.
interface skolem_sweep_ctrl_if #(
    parameter int N_IN = 8
);
    logic            start;
    logic            abort;
    logic [N_IN-1:0] vec;
    logic            sk_out;
    logic            spec_ok;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] first_fail;
    logic            first_fail_sk;
    logic            fail_seen;

    modport master (
        input  start, abort, sk_out, spec_ok,
        output vec, busy, done, pass, fail_cnt, first_fail, first_fail_sk, fail_seen
    );

    modport slave (
        output start, abort, sk_out, spec_ok,
        input  vec, busy, done, pass, fail_cnt, first_fail, first_fail_sk, fail_seen
    );
endinterface

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep of every N_IN-bit vector through a combinational Skolem block, counting checker failures.
// Latency: LAT settle cycles plus 1 sample cycle per vector; done pulses 2^N_IN*(LAT+1)+1 cycles after start.
// Backpressure: none; start is honoured only when idle, and abort drops the sweep on the next edge.
// Ports: clk, rst (async, active high); bus (master modport) carries start/abort in,
// vec out, sk_out/spec_ok in, and the status/result outputs.
module skolem_sweep_ctrl #(
    parameter int N_IN = 8,
    parameter int LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    skolem_sweep_ctrl_if.master    bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;
    logic            first_fail_sk_q, first_fail_sk_d;
    logic            fail_seen_q, fail_seen_d;

    always_comb begin
        state_d         = state_q;
        vec_d           = vec_q;
        cnt_d           = cnt_q;
        done_d          = 1'b0;
        pass_d          = pass_q;
        fail_cnt_d      = fail_cnt_q;
        first_fail_d    = first_fail_q;
        first_fail_sk_d = first_fail_sk_q;
        fail_seen_d     = fail_seen_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d         = SETTLE;
                    vec_d           = '0;
                    cnt_d           = CNT_LOAD;
                    pass_d          = 1'b0;
                    fail_cnt_d      = '0;
                    first_fail_d    = '0;
                    first_fail_sk_d = 1'b0;
                    fail_seen_d     = 1'b0;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                // An abort in this cycle discards the verdict so partial results
                // only reflect fully sampled vectors.
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    if (!bus.spec_ok) begin
                        // Width N_IN+1 holds 2^N_IN, so this never wraps.
                        fail_cnt_d = fail_cnt_q + (N_IN+1)'(1);
                        if (!fail_seen_q) begin
                            first_fail_d    = vec_q;
                            first_fail_sk_d = bus.sk_out;
                            fail_seen_d     = 1'b1;
                        end
                    end
                    if (&vec_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                pass_d  = (fail_cnt_q == '0);
            end
            default: state_d = IDLE;
        endcase

        // Decoded from the next state so the registered busy lines up with the state register.
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            vec_q           <= '0;
            cnt_q           <= 4'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_cnt_q      <= '0;
            first_fail_q    <= '0;
            first_fail_sk_q <= 1'b0;
            fail_seen_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            vec_q           <= vec_d;
            cnt_q           <= cnt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            fail_cnt_q      <= fail_cnt_d;
            first_fail_q    <= first_fail_d;
            first_fail_sk_q <= first_fail_sk_d;
            fail_seen_q     <= fail_seen_d;
        end
    end

    assign bus.vec           = vec_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.fail_cnt      = fail_cnt_q;
    assign bus.first_fail    = first_fail_q;
    assign bus.first_fail_sk = first_fail_sk_q;
    assign bus.fail_seen     = fail_seen_q;
endmodule
